// File: rtl/gaussian_window_gen.sv
// gaussian_window_gen: streaming 3x3 window generator for the Gaussian stage.
// Takes raster-order samples under valid/ready, keeps the two previous rows in
// line buffers and emits the 3x3 neighbourhood of every interior pixel.
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    input handshake, in_pixel = DATA_W-bit sample
//   win_valid/win_ready  output handshake, Ix0..Ix8 = window (row-major)
//   frame_done           one-cycle pulse after the last pixel of a frame
module gaussian_window_gen #(
  parameter int unsigned DATA_W = 27,
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [DATA_W-1:0] Ix0,
  output logic [DATA_W-1:0] Ix1,
  output logic [DATA_W-1:0] Ix2,
  output logic [DATA_W-1:0] Ix3,
  output logic [DATA_W-1:0] Ix4,
  output logic [DATA_W-1:0] Ix5,
  output logic [DATA_W-1:0] Ix6,
  output logic [DATA_W-1:0] Ix7,
  output logic [DATA_W-1:0] Ix8,
  output logic              frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] win_d [9];

  // lb0 holds row r-2, lb1 holds row r-1; neither is reset
  logic [DATA_W-1:0] lb0_q [IMG_W];
  logic [DATA_W-1:0] lb1_q [IMG_W];
  // Per-row column taps: [0] = col c-2, [1] = col c-1
  logic [DATA_W-1:0] tap2_q [2];
  logic [DATA_W-1:0] tap1_q [2];
  logic [DATA_W-1:0] tap0_q [2];

  logic              accept;
  logic              col_last;
  logic              row_last;
  logic              emit;
  logic [DATA_W-1:0] rd0;
  logic [DATA_W-1:0] rd1;

  // Single-entry output register: room whenever it is empty or draining
  assign in_ready = !win_valid_q | win_ready;
  assign accept   = in_valid & in_ready;
  assign col_last = (col_q == COL_W'(IMG_W - 1));
  assign row_last = (row_q == ROW_W'(IMG_H - 1));
  assign rd0      = lb0_q[col_q];
  assign rd1      = lb1_q[col_q];
  // c >= 2 keeps taps of the previous row out of the first windows of a row
  assign emit     = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  // Next-state: counters, output window, frame pulse
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = win_valid_q;
    win_d        = win_q;
    frame_done_d = 1'b0;
    if (win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
    end
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
        frame_done_d = row_last;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
    if (emit) begin
      win_valid_d = 1'b1;
      win_d = '{tap2_q[0], tap2_q[1], rd0,
                tap1_q[0], tap1_q[1], rd1,
                tap0_q[0], tap0_q[1], in_pixel};
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Line buffers and taps: only data movement, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      tap2_q[0]    <= tap2_q[1];
      tap2_q[1]    <= rd0;
      tap1_q[0]    <= tap1_q[1];
      tap1_q[1]    <= rd1;
      tap0_q[0]    <= tap0_q[1];
      tap0_q[1]    <= in_pixel;
      lb0_q[col_q] <= rd1;
      lb1_q[col_q] <= in_pixel;
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign Ix0 = win_q[0];
  assign Ix1 = win_q[1];
  assign Ix2 = win_q[2];
  assign Ix3 = win_q[3];
  assign Ix4 = win_q[4];
  assign Ix5 = win_q[5];
  assign Ix6 = win_q[6];
  assign Ix7 = win_q[7];
  assign Ix8 = win_q[8];

endmodule

// File: tb/tb_gaussian_window_gen.sv
// Bench for gaussian_window_gen: instance 0 is 4x4, instance 1 is 8x6.
// Expected windows are built from whole-frame arrays and queued; a monitor
// pops and compares on every output transfer.
module tb_gaussian_window_gen;

  localparam int DW = 27;
  typedef logic [9*DW-1:0] win_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid   [2];
  logic          in_ready   [2];
  logic [DW-1:0] in_pixel   [2];
  logic          win_valid  [2];
  logic          win_ready  [2];
  logic          frame_done [2];
  logic [DW-1:0] ix [2][9];

  int            rdy_mode [2];   // 0 = low, 1 = high, 2 = random
  int            win_cnt  [2];
  int            fd_cnt   [2];
  int            checks = 0;
  int            errors = 0;
  win_t          q0 [$];
  win_t          q1 [$];
  logic [DW-1:0] frm [64];
  int            first_win [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

  always #5 clk = ~clk;

  gaussian_window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_dut0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_pixel(in_pixel[0]),
    .win_valid(win_valid[0]), .win_ready(win_ready[0]),
    .Ix0(ix[0][0]), .Ix1(ix[0][1]), .Ix2(ix[0][2]), .Ix3(ix[0][3]), .Ix4(ix[0][4]),
    .Ix5(ix[0][5]), .Ix6(ix[0][6]), .Ix7(ix[0][7]), .Ix8(ix[0][8]),
    .frame_done(frame_done[0]));

  gaussian_window_gen #(.DATA_W(DW), .IMG_W(8), .IMG_H(6)) u_dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_pixel(in_pixel[1]),
    .win_valid(win_valid[1]), .win_ready(win_ready[1]),
    .Ix0(ix[1][0]), .Ix1(ix[1][1]), .Ix2(ix[1][2]), .Ix3(ix[1][3]), .Ix4(ix[1][4]),
    .Ix5(ix[1][5]), .Ix6(ix[1][6]), .Ix7(ix[1][7]), .Ix8(ix[1][8]),
    .frame_done(frame_done[1]));

  // win_ready only moves just after a rising edge
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rdy_mode[d] == 2) win_ready[d] = 1'($urandom_range(0, 1));
      else                  win_ready[d] = (rdy_mode[d] == 1);
    end
  end

  // Monitor: compare every transfer against the head of the queue
  always @(negedge clk) begin
    win_t act, exp;
    for (int d = 0; d < 2; d++) begin
      if (frame_done[d]) fd_cnt[d]++;
      if (win_valid[d] && win_ready[d]) begin
        for (int k = 0; k < 9; k++) act[k*DW +: DW] = ix[d][k];
        checks++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          errors++;
          $display("FAIL win%0d: unexpected window %h, required none", d, act);
        end else begin
          exp = (d == 0) ? q0.pop_front() : q1.pop_front();
          if (act !== exp) begin
            errors++;
            $display("FAIL win%0d: got %h required %h", d, act, exp);
          end
        end
        win_cnt[d]++;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference: every interior centre of the frame, raster order
  task automatic push_frame(input int d, input int w, input int h);
    win_t x;
    for (int r = 1; r < h - 1; r++)
      for (int c = 1; c < w - 1; c++) begin
        for (int k = 0; k < 9; k++) x[k*DW +: DW] = frm[(r - 1 + k / 3) * w + (c - 1 + k % 3)];
        if (d == 0) q0.push_back(x); else q1.push_back(x);
      end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept
  task automatic send_pixel(input int d, input logic [DW-1:0] v, input bit wexp,
                            input bit last, input bit rnd);
    bit rdy;
    if (rnd) while ($urandom_range(0, 1) == 1) @(negedge clk);
    in_valid[d] = 1'b1;
    in_pixel[d] = v;
    for (int n = 0; ; n++) begin
      rdy = in_ready[d];
      @(posedge clk);
      @(negedge clk);
      if (rdy) break;
      if (n > 1000) begin
        chk("accept_timeout", 64'(0), 64'(1));
        break;
      end
    end
    in_valid[d] = 1'b0;
    if (wexp) chk("win_latency", 64'(win_valid[d]), 64'(1));
    chk("frame_done", 64'(frame_done[d]), 64'(last));
  endtask

  task automatic send_frame(input int d, input int w, input int h, input int npix,
                            input bit rnd);
    if (npix == w * h) push_frame(d, w, h);
    for (int k = 0; k < npix; k++)
      send_pixel(d, frm[k], (k / w >= 2) && (k % w >= 2), k == w * h - 1, rnd);
  endtask

  task automatic drain(input int d);
    for (int n = 0; n < 2000 && ((d == 0) ? q0.size() : q1.size()) > 0; n++) @(negedge clk);
    chk("drain", 64'((d == 0) ? q0.size() : q1.size()), 64'(0));
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_win_valid", 64'(win_valid[d]), 64'(0));
      chk("rst_frame_done", 64'(frame_done[d]), 64'(0));
      for (int k = 0; k < 9; k++) chk("rst_ix", 64'(ix[d][k]), 64'(0));
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic count_chk(input int d, input int w0, input int wexp, input int f0, input int fexp);
    chk("win_count", 64'(win_cnt[d] - w0), 64'(wexp));
    chk("fd_count", 64'(fd_cnt[d] - f0), 64'(fexp));
  endtask

  initial begin
    int w0, f0;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_pixel[d] = '0; win_ready[d] = 1'b0;
      rdy_mode[d] = 1; win_cnt[d] = 0; fd_cnt[d] = 0;
    end
    do_reset();

    // T1: 4x4 ramp, always ready
    for (int k = 0; k < 16; k++) frm[k] = DW'(k);
    w0 = win_cnt[0]; f0 = fd_cnt[0];
    send_frame(0, 4, 4, 16, 1'b0);
    drain(0);
    count_chk(0, w0, 4, f0, 1);

    // T2: stall the first window for 5 cycles
    w0 = win_cnt[0]; f0 = fd_cnt[0];
    rdy_mode[0] = 0;
    @(posedge clk); #1; @(negedge clk);
    fork
      send_frame(0, 4, 4, 16, 1'b0);
      begin
        for (int n = 0; n < 200 && !win_valid[0]; n++) @(negedge clk);
        chk("stall_seen", 64'(win_valid[0]), 64'(1));
        for (int s = 0; s < 5; s++) begin
          chk("stall_in_ready", 64'(in_ready[0]), 64'(0));
          for (int k = 0; k < 9; k++) chk("stall_ix", 64'(ix[0][k]), 64'(first_win[k]));
          @(negedge clk);
        end
        rdy_mode[0] = 1;
      end
    join
    drain(0);
    count_chk(0, w0, 4, f0, 1);

    // T3: back-to-back frames 0..15 then 100..115
    w0 = win_cnt[0]; f0 = fd_cnt[0];
    send_frame(0, 4, 4, 16, 1'b0);
    for (int k = 0; k < 16; k++) frm[k] = DW'(100 + k);
    send_frame(0, 4, 4, 16, 1'b0);
    drain(0);
    count_chk(0, w0, 8, f0, 2);

    // T4: reset after pixel 9, then a pending window discarded by reset, then full frame
    for (int k = 0; k < 16; k++) frm[k] = DW'(k);
    send_frame(0, 4, 4, 10, 1'b0);
    do_reset();
    rdy_mode[0] = 0;
    send_frame(0, 4, 4, 11, 1'b0);
    do_reset();
    rdy_mode[0] = 1;
    w0 = win_cnt[0]; f0 = fd_cnt[0];
    send_frame(0, 4, 4, 16, 1'b0);
    drain(0);
    count_chk(0, w0, 4, f0, 1);

    // T5: negative samples -(k+1)
    for (int k = 0; k < 16; k++) frm[k] = DW'(-(k + 1));
    w0 = win_cnt[0]; f0 = fd_cnt[0];
    send_frame(0, 4, 4, 16, 1'b0);
    drain(0);
    count_chk(0, w0, 4, f0, 1);

    // T6: 8x6 random data, random in_valid and win_ready
    for (int k = 0; k < 48; k++) frm[k] = DW'($urandom);
    rdy_mode[1] = 2;
    w0 = win_cnt[1]; f0 = fd_cnt[1];
    send_frame(1, 8, 6, 48, 1'b1);
    drain(1);
    rdy_mode[1] = 1;
    repeat (4) @(negedge clk);
    count_chk(1, w0, 24, f0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

endmodule
